// File: rtl/eth_rx_filter_pkg.sv
// Shared definitions for the Ethernet receive filter: FSM encoding and header constants.
package eth_rx_filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PASS = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  localparam logic [47:0] BCAST_MAC        = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] DEFAULT_ETH_TYPE = 16'h88b6;

endpackage

// File: rtl/eth_rx_filter_match.sv
// Combinational destination-MAC / EtherType comparator, reusable by other header checkers.
module eth_rx_filter_match
  import eth_rx_filter_pkg::*;
#(
  parameter bit ALLOW_BROADCAST = 1'b1,
  parameter bit MATCH_TYPE      = 1'b1
) (
  input  logic [47:0] dest_mac_i,
  input  logic [47:0] local_mac_i,
  input  logic [15:0] eth_type_i,
  input  logic [15:0] cfg_type_i,
  output logic        match_o
);

  logic mac_ok;
  logic type_ok;

  assign mac_ok  = (dest_mac_i == local_mac_i) ||
                   (ALLOW_BROADCAST && (dest_mac_i == BCAST_MAC));
  assign type_ok = !MATCH_TYPE || (eth_type_i == cfg_type_i);
  assign match_o = mac_ok && type_ok;

endmodule

// File: rtl/eth_rx_filter.sv
// Receive frame filter: forwards frames addressed to us (registered header, pass-through
// payload) and drains the rest. Optional pass/drop counters with ETH_RX_FILTER_STATS_EN.
module eth_rx_filter
  import eth_rx_filter_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int ALLOW_BROADCAST = 1,
  parameter int MATCH_TYPE      = 1,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [47:0]           cfg_local_mac,
  input  logic [15:0]           cfg_eth_type,
  // All channels: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and a source holds its data until the transfer.
  input  logic                  s_eth_hdr_valid,
  output logic                  s_eth_hdr_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic                  s_eth_payload_axis_tvalid,
  output logic                  s_eth_payload_axis_tready,
  input  logic                  s_eth_payload_axis_tlast,
  input  logic                  s_eth_payload_axis_tuser,
  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic                  m_eth_payload_axis_tvalid,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser,
`ifdef ETH_RX_FILTER_STATS_EN
  output logic [CNT_WIDTH-1:0]  pass_count,
  output logic [CNT_WIDTH-1:0]  drop_count,
`endif
  output logic [1:0]            dbg_state_o
);

  state_e      state_q, state_d;
  logic        match;
  logic        hdr_fire;
  logic [47:0] dest_q, src_q;
  logic [15:0] type_q;

  eth_rx_filter_match #(
    .ALLOW_BROADCAST (ALLOW_BROADCAST != 0),
    .MATCH_TYPE      (MATCH_TYPE != 0)
  ) u_match (
    .dest_mac_i  (s_eth_dest_mac),
    .local_mac_i (cfg_local_mac),
    .eth_type_i  (s_eth_type),
    .cfg_type_i  (cfg_eth_type),
    .match_o     (match)
  );

  assign hdr_fire = (state_q == ST_IDLE) && s_eth_hdr_valid;

  always_comb begin
    state_d                   = state_q;
    s_eth_hdr_ready           = 1'b0;
    s_eth_payload_axis_tready = 1'b0;
    m_eth_payload_axis_tvalid = 1'b0;
    m_eth_hdr_valid           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_eth_hdr_ready = 1'b1;
        if (s_eth_hdr_valid) state_d = match ? ST_HDR : ST_DROP;
      end
      ST_HDR: begin
        m_eth_hdr_valid = 1'b1;
        if (m_eth_hdr_ready) state_d = ST_PASS;
      end
      ST_PASS: begin
        m_eth_payload_axis_tvalid = s_eth_payload_axis_tvalid;
        s_eth_payload_axis_tready = m_eth_payload_axis_tready;
        if (s_eth_payload_axis_tvalid && m_eth_payload_axis_tready && s_eth_payload_axis_tlast)
          state_d = ST_IDLE;
      end
      ST_DROP: begin
        s_eth_payload_axis_tready = 1'b1;
        if (s_eth_payload_axis_tvalid && s_eth_payload_axis_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dest_q  <= '0;
      src_q   <= '0;
      type_q  <= '0;
    end else begin
      state_q <= state_d;
      if (hdr_fire && match) begin
        dest_q <= s_eth_dest_mac;
        src_q  <= s_eth_src_mac;
        type_q <= s_eth_type;
      end
    end
  end

  assign m_eth_dest_mac           = dest_q;
  assign m_eth_src_mac            = src_q;
  assign m_eth_type               = type_q;
  // Data sidebands flow straight through; tvalid alone decides whether a beat exists.
  assign m_eth_payload_axis_tdata = s_eth_payload_axis_tdata;
  assign m_eth_payload_axis_tlast = s_eth_payload_axis_tlast;
  assign m_eth_payload_axis_tuser = s_eth_payload_axis_tuser;
  assign dbg_state_o              = state_q;

`ifdef ETH_RX_FILTER_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] pass_q, drop_q;

  // Counters stop at all-ones so a long soak never appears to restart from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q <= '0;
      drop_q <= '0;
    end else if (hdr_fire) begin
      if (match) begin
        if (pass_q != '1) pass_q <= pass_q + CNT_ONE;
      end else begin
        if (drop_q != '1) drop_q <= drop_q + CNT_ONE;
      end
    end
  end

  assign pass_count = pass_q;
  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_eth_rx_filter.sv
// Self-checking bench for eth_rx_filter: frame-level scoreboard plus directed timing checks.
module tb_eth_rx_filter;
  import eth_rx_filter_pkg::*;

  localparam int DW = 8;
  localparam int CW = 16;
  localparam logic [47:0] LOCAL_MAC = 48'h07_08_09_0a_0b_0c;
  localparam logic [47:0] OTHER_MAC = 48'h01_02_03_04_05_06;
  localparam logic [47:0] ALL_ONES  = 48'hffff_ffff_ffff;
  localparam logic [15:0] IP_TYPE   = 16'h0800;

  logic          clk, rst_n;
  logic [47:0]   cfg_local_mac;
  logic [15:0]   cfg_eth_type;
  logic          s_hdr_valid, s_hdr_ready;
  logic [47:0]   s_dest, s_src;
  logic [15:0]   s_type;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tready, s_tlast, s_tuser;
  logic          m_hdr_valid, m_hdr_ready;
  logic [47:0]   m_dest, m_src;
  logic [15:0]   m_type;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tready, m_tlast, m_tuser;
  logic [1:0]    dbg_state;
  logic [CW-1:0] pass_count, drop_count;

  logic          b_hdr_valid, b_hdr_ready;
  logic [47:0]   b_dest;
  logic [15:0]   b_type;
  logic [DW-1:0] b_tdata;
  logic          b_tvalid, b_tready, b_tlast;
  logic          b_m_hdr_valid;
  logic [47:0]   b_m_dest, b_m_src;
  logic [15:0]   b_m_type;
  logic [DW-1:0] b_m_tdata;
  logic          b_m_tvalid, b_m_tlast, b_m_tuser;
  logic [1:0]    b_dbg_state;
  logic [CW-1:0] b_pass_count, b_drop_count;

  eth_rx_filter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_local_mac(cfg_local_mac), .cfg_eth_type(cfg_eth_type),
    .s_eth_hdr_valid(s_hdr_valid), .s_eth_hdr_ready(s_hdr_ready),
    .s_eth_dest_mac(s_dest), .s_eth_src_mac(s_src), .s_eth_type(s_type),
    .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tvalid(s_tvalid),
    .s_eth_payload_axis_tready(s_tready), .s_eth_payload_axis_tlast(s_tlast),
    .s_eth_payload_axis_tuser(s_tuser),
    .m_eth_hdr_valid(m_hdr_valid), .m_eth_hdr_ready(m_hdr_ready),
    .m_eth_dest_mac(m_dest), .m_eth_src_mac(m_src), .m_eth_type(m_type),
    .m_eth_payload_axis_tdata(m_tdata), .m_eth_payload_axis_tvalid(m_tvalid),
    .m_eth_payload_axis_tready(m_tready), .m_eth_payload_axis_tlast(m_tlast),
    .m_eth_payload_axis_tuser(m_tuser),
`ifdef ETH_RX_FILTER_STATS_EN
    .pass_count(pass_count), .drop_count(drop_count),
`endif
    .dbg_state_o(dbg_state)
  );

  eth_rx_filter #(.DATA_WIDTH(DW), .ALLOW_BROADCAST(0), .MATCH_TYPE(0), .CNT_WIDTH(CW)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_local_mac(cfg_local_mac), .cfg_eth_type(cfg_eth_type),
    .s_eth_hdr_valid(b_hdr_valid), .s_eth_hdr_ready(b_hdr_ready),
    .s_eth_dest_mac(b_dest), .s_eth_src_mac(48'h0000_0000_00b0), .s_eth_type(b_type),
    .s_eth_payload_axis_tdata(b_tdata), .s_eth_payload_axis_tvalid(b_tvalid),
    .s_eth_payload_axis_tready(b_tready), .s_eth_payload_axis_tlast(b_tlast),
    .s_eth_payload_axis_tuser(1'b0),
    .m_eth_hdr_valid(b_m_hdr_valid), .m_eth_hdr_ready(1'b1),
    .m_eth_dest_mac(b_m_dest), .m_eth_src_mac(b_m_src), .m_eth_type(b_m_type),
    .m_eth_payload_axis_tdata(b_m_tdata), .m_eth_payload_axis_tvalid(b_m_tvalid),
    .m_eth_payload_axis_tready(1'b1), .m_eth_payload_axis_tlast(b_m_tlast),
    .m_eth_payload_axis_tuser(b_m_tuser),
`ifdef ETH_RX_FILTER_STATS_EN
    .pass_count(b_pass_count), .drop_count(b_drop_count),
`endif
    .dbg_state_o(b_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #4 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [DW+1:0]  exp_q[$];      // {tlast, tuser, tdata}
  logic [111:0]   exp_hdr_q[$];  // {dest, src, type}
  int exp_pass = 0, exp_drop = 0, frame_no = 0;
  int hs_cyc, hv_cyc, hv_cnt, first_out, last_in, in_beats, out_beats;
  bit hdr_done = 0, hv_pending = 0, last_out_user = 0, bp_en = 0;
  logic [111:0] held_hdr;
  int b_hv_cnt, b_out, b_in;
  logic [15:0] b_type_seen;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_match(input logic [47:0] dest, input logic [15:0] typ,
                                     input bit allow_bc, input bit match_type);
    bit mac_ok;
    mac_ok = (dest == cfg_local_mac) || (allow_bc && dest == ALL_ONES);
    return mac_ok && (!match_type || typ == cfg_eth_type);
  endfunction

  function automatic logic [DW-1:0] beat_data(input int i, input int f);
    return DW'(i * 3 + f);
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_hdr_valid = 1'b0;
    s_tvalid    = 1'b0;
    s_tlast     = 1'b0;
    s_tuser     = 1'b0;
  endtask

  // Starts right after a posedge; header and first beat are offered together.
  task automatic send_frame(input logic [47:0] dest, input logic [15:0] typ,
                            input int len, input bit last_user);
    logic [47:0] src;
    bit hs, acc;
    int t;
    frame_no++;
    src = {32'ha0a1_a2a3, 16'(frame_no)};
    if (model_match(dest, typ, 1'b1, 1'b1)) begin
      exp_pass++;
      exp_hdr_q.push_back({dest, src, typ});
      for (int i = 0; i < len; i++)
        exp_q.push_back({(i == len - 1), (i == len - 1) && last_user, beat_data(i, frame_no)});
    end else begin
      exp_drop++;
    end
    s_hdr_valid = 1'b1; s_dest = dest; s_src = src; s_type = typ;
    s_tvalid = 1'b1; s_tdata = beat_data(0, frame_no);
    s_tlast = (len == 1); s_tuser = (len == 1) && last_user;
    hs = 1'b0; t = 0;
    while (!hs) begin
      @(negedge clk);
      hs = s_hdr_ready;
      sync();
      if (!rst_n) begin idle_inputs(); return; end
      if (++t > 2000) begin check("hdr_accept_timeout", 0, 1); idle_inputs(); return; end
    end
    s_hdr_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      s_tdata = beat_data(i, frame_no);
      s_tlast = (i == len - 1);
      s_tuser = (i == len - 1) && last_user;
      acc = 1'b0; t = 0;
      while (!acc) begin
        @(negedge clk);
        acc = s_tvalid && s_tready;
        sync();
        if (!rst_n) begin idle_inputs(); return; end
        if (++t > 2000) begin check("beat_accept_timeout", 0, 1); idle_inputs(); return; end
      end
    end
    idle_inputs();
  endtask

  task automatic send_b(input logic [47:0] dest, input logic [15:0] typ, input int len);
    bit done;
    int t;
    b_hv_cnt = 0; b_out = 0; b_in = 0; b_type_seen = '0;
    b_hdr_valid = 1'b1; b_dest = dest; b_type = typ;
    done = 1'b0; t = 0;
    while (!done) begin
      @(negedge clk);
      done = b_hdr_ready;
      sync();
      if (++t > 2000) begin check("b_hdr_timeout", 0, 1); b_hdr_valid = 1'b0; return; end
    end
    b_hdr_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      b_tvalid = 1'b1; b_tdata = DW'(i); b_tlast = (i == len - 1);
      done = 1'b0; t = 0;
      while (!done) begin
        @(negedge clk);
        done = b_tready;
        sync();
        if (++t > 2000) begin check("b_beat_timeout", 0, 1); b_tvalid = 1'b0; return; end
      end
    end
    b_tvalid = 1'b0; b_tlast = 1'b0;
    repeat (3) sync();
  endtask

  task automatic check_stats(input string name);
`ifdef ETH_RX_FILTER_STATS_EN
    check({name, "_pass_count"}, pass_count, exp_pass);
    check({name, "_drop_count"}, drop_count, exp_drop);
`else
    check({name, "_queue_drained"}, exp_q.size(), 0);
`endif
  endtask

  // ---------------- compare process ----------------
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (s_hdr_valid && s_hdr_ready) begin
        hs_cyc = cyc; hv_cyc = -1; hv_cnt = 0; first_out = -1; last_in = -1;
        in_beats = 0; out_beats = 0; hdr_done = 0;
      end
      if (m_hdr_valid) begin
        if (hv_cyc < 0) hv_cyc = cyc;
        hv_cnt++;
        check("m_tvalid_during_hdr", m_tvalid, 0);
        if (hv_pending) check("hdr_stable", {m_dest, m_src, m_type}, held_hdr);
        if (m_hdr_ready) begin
          hv_pending = 0;
          hdr_done = 1;
          if (exp_hdr_q.size() == 0) check("hdr_unexpected", 1, 0);
          else check("hdr_fields", {m_dest, m_src, m_type}, exp_hdr_q.pop_front());
        end else begin
          hv_pending = 1;
          held_hdr = {m_dest, m_src, m_type};
        end
      end else if (hv_pending) begin
        check("hdr_valid_dropped", 0, 1);
        hv_pending = 0;
      end
      if (m_tvalid) begin
        check("m_tvalid_outside_pass", hdr_done, 1);
        if (m_tready) begin
          out_beats++;
          if (first_out < 0) first_out = cyc;
          if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
          else check("beat", {m_tlast, m_tuser, m_tdata}, exp_q.pop_front());
          if (m_tlast) begin last_out_user = m_tuser; hdr_done = 0; end
        end
      end
      if (s_tvalid && s_tready) begin
        in_beats++;
        if (s_tlast) last_in = cyc;
      end
      if (b_m_hdr_valid) begin b_hv_cnt++; b_type_seen = b_m_type; end
      if (b_m_tvalid) b_out++;
      if (b_tvalid && b_tready) b_in++;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #2_000_000;
    check("global_timeout", 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- directed sequence ----------------
  int prev_last, w;

  initial begin
    rst_n = 1'b0;
    cfg_local_mac = LOCAL_MAC; cfg_eth_type = DEFAULT_ETH_TYPE;
    idle_inputs(); s_dest = '0; s_src = '0; s_type = '0; s_tdata = '0;
    b_hdr_valid = 1'b0; b_dest = '0; b_type = '0; b_tdata = '0; b_tvalid = 1'b0; b_tlast = 1'b0;
    m_hdr_ready = 1'b1; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_state", dbg_state, 0);
    check("rst_hdr_ready", s_hdr_ready, 1);
    check("rst_hdr_valid", m_hdr_valid, 0);
    check("rst_hdr_fields", {m_dest, m_src, m_type}, 0);
    check("rst_tvalid", m_tvalid, 0);
    check_stats("rst");

    // 1: matching frame, 256 beats, no backpressure
    sync();
    send_frame(LOCAL_MAC, DEFAULT_ETH_TYPE, 256, 1'b0);
    check("t1_hdr_latency", hv_cyc - hs_cyc, 1);
    check("t1_first_beat_latency", first_out - hs_cyc, 2);
    check("t1_last_beat", last_in - hs_cyc, 257);
    check("t1_out_beats", out_beats, 256);
    check("t1_hdr_cycles", hv_cnt, 1);
    check("t1_queue_empty", exp_q.size(), 0);
    check_stats("t1");

    // 2: foreign dest drained, then a matching frame right behind it
    send_frame(OTHER_MAC, DEFAULT_ETH_TYPE, 256, 1'b0);
    check("t2_no_hdr", hv_cnt, 0);
    check("t2_in_beats", in_beats, 256);
    check("t2_drain_cycles", last_in - hs_cyc, 256);
    check("t2_out_beats", out_beats, 0);
    check_stats("t2_drop");
    prev_last = last_in;
    send_frame(LOCAL_MAC, DEFAULT_ETH_TYPE, 16, 1'b0);
    check("t2_dead_cycle", hs_cyc - prev_last, 1);
    check("t2_follow_out_beats", out_beats, 16);
    check_stats("t2_follow");

    // 3 and 4 on the default instance
    send_frame(ALL_ONES, DEFAULT_ETH_TYPE, 8, 1'b0);
    check("t3_bcast_hdr", hv_cnt, 1);
    check("t3_bcast_out", out_beats, 8);
    send_frame(LOCAL_MAC, IP_TYPE, 8, 1'b0);
    check("t4_type_drop_hdr", hv_cnt, 0);
    check("t4_type_drop_in", in_beats, 8);
    check_stats("t34");

    // 3 and 4 on the broadcast-off / any-type instance
    send_b(ALL_ONES, DEFAULT_ETH_TYPE, 4);
    check("t3b_bcast_hdr", b_hv_cnt, 0);
    check("t3b_bcast_in", b_in, 4);
    check("t3b_bcast_out", b_out, 0);
    send_b(LOCAL_MAC, IP_TYPE, 4);
    check("t4b_any_type_hdr", b_hv_cnt, 1);
    check("t4b_any_type_field", b_type_seen, IP_TYPE);
    check("t4b_any_type_out", b_out, 4);

    // 5: header held off 10 cycles, random payload backpressure, tuser on last beat
    bp_en = 1'b1;
    m_hdr_ready = 1'b0;
    fork
      send_frame(LOCAL_MAC, DEFAULT_ETH_TYPE, 64, 1'b1);
      begin
        w = 0;
        while (!m_hdr_valid && w < 200) begin @(negedge clk); w++; end
        check("t5_hdr_seen", m_hdr_valid, 1);
        repeat (10) @(negedge clk);
        sync();
        m_hdr_ready = 1'b1;
      end
    join
    bp_en = 1'b0;
    check("t5_hdr_cycles", hv_cnt, 12);
    check("t5_out_beats", out_beats, 64);
    check("t5_last_tuser", last_out_user, 1);
    check("t5_queue_empty", exp_q.size(), 0);
    check_stats("t5");

    // 6: reset in the middle of a passed frame
    fork
      send_frame(LOCAL_MAC, DEFAULT_ETH_TYPE, 256, 1'b0);
      begin
        w = 0;
        while (out_beats < 100 && w < 3000) begin @(negedge clk); w++; end
        check("t6_reached_beat_100", out_beats >= 100, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_state", dbg_state, 0);
        check("t6_rst_tvalid", m_tvalid, 0);
        check("t6_rst_hdr_valid", m_hdr_valid, 0);
        check("t6_rst_hdr_fields", {m_dest, m_src, m_type}, 0);
        check("t6_rst_hdr_ready", s_hdr_ready, 1);
        exp_q.delete(); exp_hdr_q.delete();
        exp_pass = 0; exp_drop = 0; hv_pending = 0; hdr_done = 0;
        check_stats("t6_rst");
      end
    join
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sync();
    send_frame(LOCAL_MAC, DEFAULT_ETH_TYPE, 32, 1'b0);
    check("t6_after_out_beats", out_beats, 32);
    check("t6_after_hdr_latency", hv_cyc - hs_cyc, 1);
    check_stats("t6_after");
    check("final_hdr_queue_empty", exp_hdr_q.size(), 0);

    repeat (4) sync();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
